// File: rtl/ryu_knockback.sv
// rtl/ryu_knockback.sv - hit-driven decaying knockback push followed by a stun window
module ryu_knockback #(
  parameter int KB_LIGHT    = 2,
  parameter int KB_MED      = 4,
  parameter int KB_HEAVY    = 6,
  parameter int PUSH_FRAMES = 8,
  parameter int DECAY_INT   = 2,
  parameter int STUN_FRAMES = 12,
  parameter int BOUND_X_MIN = 7,
  parameter int BOUND_X_MAX = 513
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        hit,
  input  logic [1:0]  hit_strength,
  input  logic        hit_dir,
  input  logic        blocking,
  input  logic [9:0]  RyuX,
  output logic [31:0] Ryu_Knockback,
  output logic        Ryu_Stun,
  output logic        kb_active
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PUSH    = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_speed;
  logic [3:0]  r_dec;
  logic [3:0]  r_cnt;
  logic        r_dir;

  logic        w_load;
  logic [3:0]  w_base_speed;
  logic [3:0]  w_half_speed;
  logic [3:0]  w_load_speed;
  logic [3:0]  w_cur_speed;
  logic [3:0]  w_cur_dec;
  logic        w_cur_dir;
  logic [3:0]  w_dec_inc;
  logic [3:0]  w_next_dec;
  logic [3:0]  w_next_speed;
  logic [10:0] w_x;
  logic [10:0] w_room_left;
  logic [10:0] w_room_right;
  logic [10:0] w_room;
  logic [3:0]  w_mag;
  logic [31:0] w_mag32;
  logic [31:0] w_kb;

  assign w_load = hit && (hit_strength != 2'd0);

  // Initial push speed selected by hit strength
  always_comb begin
    w_base_speed = 4'd0;
    case (hit_strength)
      2'd1:    w_base_speed = 4'(KB_LIGHT);
      2'd2:    w_base_speed = 4'(KB_MED);
      2'd3:    w_base_speed = 4'(KB_HEAVY);
      default: w_base_speed = 4'd0;
    endcase
  end

  // A guarded hit pushes at half speed but always moves at least 1 px
  assign w_half_speed = w_base_speed >> 1;
  assign w_load_speed = blocking ? ((w_half_speed == 4'd0) ? 4'd1 : w_half_speed) : w_base_speed;

  // A fresh hit starts from the loaded speed with a cleared decay counter
  assign w_cur_speed = w_load ? w_load_speed : r_speed;
  assign w_cur_dec   = w_load ? 4'd0 : r_dec;
  assign w_cur_dir   = w_load ? hit_dir : r_dir;

  // The frame being emitted counts toward the decay interval; speed for the next frame drops when it fills
  assign w_dec_inc    = w_cur_dec + 4'd1;
  assign w_next_dec   = (w_dec_inc == 4'(DECAY_INT)) ? 4'd0 : w_dec_inc;
  assign w_next_speed = (w_dec_inc == 4'(DECAY_INT) && w_cur_speed > 4'd1) ? (w_cur_speed - 4'd1) : w_cur_speed;

  // Wall clamp: never push Ryu past either stage boundary
  assign w_x          = {1'b0, RyuX};
  assign w_room_left  = (w_x > 11'(BOUND_X_MIN)) ? (w_x - 11'(BOUND_X_MIN)) : 11'd0;
  assign w_room_right = (w_x < 11'(BOUND_X_MAX)) ? (11'(BOUND_X_MAX) - w_x) : 11'd0;
  assign w_room       = w_cur_dir ? w_room_left : w_room_right;
  assign w_mag        = ({7'd0, w_cur_speed} < w_room) ? w_cur_speed : w_room[3:0];
  assign w_mag32      = {28'd0, w_mag};
  assign w_kb         = w_cur_dir ? (32'd0 - w_mag32) : w_mag32;

  // Frame-rate FSM: a valid hit always (re)starts the push, otherwise walk PUSH -> RECOVER -> IDLE
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= IDLE;
      r_speed       <= 4'd0;
      r_dec         <= 4'd0;
      r_cnt         <= 4'd0;
      r_dir         <= 1'b0;
      Ryu_Knockback <= 32'd0;
      Ryu_Stun      <= 1'b0;
      kb_active     <= 1'b0;
    end else if (w_load) begin
      r_state       <= PUSH;
      r_cnt         <= 4'(PUSH_FRAMES - 1);
      r_speed       <= w_next_speed;
      r_dec         <= w_next_dec;
      r_dir         <= hit_dir;
      Ryu_Knockback <= w_kb;
      Ryu_Stun      <= 1'b1;
      kb_active     <= 1'b1;
    end else begin
      case (r_state)
        PUSH: begin
          if (r_cnt != 4'd0) begin
            r_cnt         <= r_cnt - 4'd1;
            r_speed       <= w_next_speed;
            r_dec         <= w_next_dec;
            Ryu_Knockback <= w_kb;
            Ryu_Stun      <= 1'b1;
            kb_active     <= 1'b1;
          end else begin
            r_state       <= RECOVER;
            r_cnt         <= 4'(STUN_FRAMES - 1);
            r_speed       <= 4'd0;
            r_dec         <= 4'd0;
            Ryu_Knockback <= 32'd0;
            Ryu_Stun      <= 1'b1;
            kb_active     <= 1'b0;
          end
        end
        RECOVER: begin
          Ryu_Knockback <= 32'd0;
          kb_active     <= 1'b0;
          if (r_cnt != 4'd0) begin
            r_cnt    <= r_cnt - 4'd1;
            Ryu_Stun <= 1'b1;
          end else begin
            r_state  <= IDLE;
            Ryu_Stun <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_cnt         <= 4'd0;
          Ryu_Knockback <= 32'd0;
          Ryu_Stun      <= 1'b0;
          kb_active     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ryu_knockback.sv
// tb/tb_ryu_knockback.sv - scoreboard bench for ryu_knockback against a frame-index reference model
module tb_ryu_knockback;

  localparam int PF = 8;
  localparam int SF = 12;

  logic        frame_clk;
  logic        Reset_n;
  logic        hit;
  logic [1:0]  hit_strength;
  logic        hit_dir;
  logic        blocking;
  logic [9:0]  RyuX;
  logic [31:0] Ryu_Knockback;
  logic        Ryu_Stun;
  logic        kb_active;

  typedef struct {
    int kb;
    bit stun;
    bit act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: frames since the last valid hit (-1 = idle)
  int   m_k   = -1;
  int   m_s0  = 0;
  bit   m_dir = 1'b0;

  ryu_knockback dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .hit           (hit),
    .hit_strength  (hit_strength),
    .hit_dir       (hit_dir),
    .blocking      (blocking),
    .RyuX          (RyuX),
    .Ryu_Knockback (Ryu_Knockback),
    .Ryu_Stun      (Ryu_Stun),
    .kb_active     (kb_active)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Monitor: outputs are presented every frame; compare against the oldest expectation
  always @(negedge frame_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 3;
      if ($signed(Ryu_Knockback) != e.kb) begin
        errors = errors + 1;
        $display("FAIL knockback t=%0t got %0d want %0d", $time, $signed(Ryu_Knockback), e.kb);
      end
      if (Ryu_Stun !== e.stun) begin
        errors = errors + 1;
        $display("FAIL stun t=%0t got %b want %b", $time, Ryu_Stun, e.stun);
      end
      if (kb_active !== e.act) begin
        errors = errors + 1;
        $display("FAIL kb_active t=%0t got %b want %b", $time, kb_active, e.act);
      end
    end
  end

  // One frame of stimulus; the model predicts the outputs registered at the coming edge
  task automatic step(input bit h, input int st, input bit d, input bit b, input int x, input bit rn);
    bit   prev_rn;
    exp_t e;
    int   sp;
    int   room;
    @(negedge frame_clk);
    #1;
    prev_rn      = Reset_n;
    Reset_n      = rn;
    hit          = h;
    hit_strength = 2'(st);
    hit_dir      = d;
    blocking     = b;
    RyuX         = 10'(x);
    if (prev_rn && !rn) begin
      #1;
      checks = checks + 3;
      if (Ryu_Knockback != 32'd0) begin
        errors = errors + 1;
        $display("FAIL async_reset_kb got %0d want 0", $signed(Ryu_Knockback));
      end
      if (Ryu_Stun !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL async_reset_stun got %b want 0", Ryu_Stun);
      end
      if (kb_active !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL async_reset_active got %b want 0", kb_active);
      end
    end
    if (!rn) begin
      m_k = -1;
    end else if (h && st != 0) begin
      m_k   = 0;
      m_dir = d;
      case (st)
        1:       m_s0 = 2;
        2:       m_s0 = 4;
        default: m_s0 = 6;
      endcase
      if (b) m_s0 = (m_s0 / 2 < 1) ? 1 : m_s0 / 2;
    end else if (m_k >= 0) begin
      m_k = m_k + 1;
      if (m_k >= PF + SF) m_k = -1;
    end
    e.kb = 0; e.stun = 1'b0; e.act = 1'b0;
    if (m_k >= 0 && m_k < PF) begin
      sp = m_s0 - m_k / 2;
      if (sp < 1) sp = 1;
      if (m_dir) room = (x > 7) ? x - 7 : 0;
      else       room = (x < 513) ? 513 - x : 0;
      if (room < sp) sp = room;
      e.kb   = m_dir ? -sp : sp;
      e.stun = 1'b1;
      e.act  = 1'b1;
    end else if (m_k >= PF) begin
      e.stun = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input int x);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, x, 1'b1);
  endtask

  initial begin
    Reset_n = 1'b0; hit = 1'b0; hit_strength = 2'd0; hit_dir = 1'b0; blocking = 1'b0; RyuX = 10'd200;
    step(1'b0, 0, 1'b0, 1'b0, 200, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 200, 1'b0);
    idle(6, 200);
    // heavy, rightward, unguarded
    step(1'b1, 3, 1'b0, 1'b0, 200, 1'b1);
    idle(24, 200);
    // heavy, leftward, guarded
    step(1'b1, 3, 1'b1, 1'b1, 200, 1'b1);
    idle(24, 200);
    // medium leftward near the left wall, then held at the wall
    step(1'b1, 2, 1'b1, 1'b0, 9, 1'b1);
    idle(22, 7);
    // light rightward at the right wall edge
    step(1'b1, 1, 1'b0, 1'b0, 512, 1'b1);
    idle(22, 512);
    // light re-hit at push frame 5 of a heavy push
    step(1'b1, 3, 1'b0, 1'b0, 200, 1'b1);
    idle(4, 200);
    step(1'b1, 1, 1'b0, 1'b0, 200, 1'b1);
    idle(24, 200);
    // re-hit during recovery, strength-0 hits ignored
    step(1'b1, 3, 1'b1, 1'b0, 300, 1'b1);
    idle(3, 300);
    step(1'b1, 0, 1'b0, 1'b0, 300, 1'b1);
    idle(8, 300);
    step(1'b1, 2, 1'b0, 1'b1, 300, 1'b1);
    idle(24, 300);
    // reset during push frame 3
    step(1'b1, 3, 1'b0, 1'b0, 200, 1'b1);
    idle(2, 200);
    step(1'b0, 0, 1'b0, 1'b0, 200, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 200, 1'b0);
    idle(6, 200);
    // randomized frames
    for (int i = 0; i < 800; i++) begin
      bit h;
      int x;
      h = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       x = $urandom_range(0, 14);
        1:       x = $urandom_range(505, 1023);
        default: x = $urandom_range(0, 1023);
      endcase
      step(h, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x,
           ($urandom_range(0, 199) != 0));
    end
    @(negedge frame_clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
